// File: rtl/data_memory_unit.sv
// data_memory_unit
//   Byte-addressable RV32I data memory with a valid/ready request port,
//   sub-word loads/stores, alignment/range fault detection and a fixed
//   response latency of LATENCY cycles (1..4).
//
// Ports
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   req_valid/ready : request handshake (accept on valid && ready)
//   req_write       : 1 = store, 0 = load
//   req_funct3      : RV32I width code (B/H/W/BU/HU)
//   req_addr        : byte address
//   req_wdata       : low-aligned store data
//   resp_valid      : one-cycle response strobe, no backpressure
//   resp_rdata      : extended load data, 0 for stores/faults/idle cycles
//   resp_error      : request faulted (only meaningful with resp_valid)
//   initial_values  : memory image loaded while reset is high
//   memory_check    : live view of every memory word
module data_memory_unit #(
  parameter int DEPTH_WORDS = 32,
  parameter int LATENCY     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [2:0]                   req_funct3,
  input  logic [31:0]                  req_addr,
  input  logic [31:0]                  req_wdata,
  output logic                         resp_valid,
  output logic [31:0]                  resp_rdata,
  output logic                         resp_error,
  input  logic [DEPTH_WORDS-1:0][31:0] initial_values,
  output logic [DEPTH_WORDS-1:0][31:0] memory_check
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RELOAD = 2'(LATENCY - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                         state_q, state_d;
  logic [1:0]                     cnt_q, cnt_d;
  logic [31:0]                    data_q, data_d;
  logic                           err_q, err_d;
  logic                           resp_valid_q, resp_error_q;
  logic [31:0]                    resp_rdata_q;
  logic [DEPTH_WORDS-1:0][31:0]   mem_q;

  logic          accept;
  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic          fault;
  logic [31:0]   ld_ext;
  logic [31:0]   ld_val;
  logic [3:0]    be;
  logic [31:0]   wd_lanes;
  logic          fire_d;

  assign req_ready    = (state_q == IDLE) || resp_valid_q;
  assign accept       = req_valid && req_ready;
  assign idx          = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign word         = mem_q[idx];
  assign sel_byte     = word[{lane, 3'b000} +: 8];
  assign sel_half     = lane[1] ? word[31:16] : word[15:0];
  assign memory_check = mem_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_error   = resp_error_q;

  // Fault decode: misalignment, illegal width, store with unsigned width,
  // or any address bit above the array.
  always_comb begin
    fault = 1'b0;
    case (req_funct3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = lane[0];
      3'b010:  fault = (lane != 2'b00);
      3'b100:  fault = req_write;
      3'b101:  fault = req_write | lane[0];
      default: fault = 1'b1;
    endcase
    if (req_addr[31:AW+2] != '0) fault = 1'b1;
  end

  always_comb begin
    ld_ext = '0;
    case (req_funct3)
      3'b000:  ld_ext = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ld_ext = {24'h0, sel_byte};
      3'b001:  ld_ext = {{16{sel_half[15]}}, sel_half};
      3'b101:  ld_ext = {16'h0, sel_half};
      3'b010:  ld_ext = word;
      default: ld_ext = '0;
    endcase
    ld_val = (fault || req_write) ? 32'h0 : ld_ext;
  end

  // Store data is replicated across lanes so each byte enable picks
  // its own slice directly.
  always_comb begin
    be       = 4'b0000;
    wd_lanes = req_wdata;
    if (accept && req_write && !fault) begin
      case (req_funct3)
        3'b000: begin
          be       = 4'b0001 << lane;
          wd_lanes = {4{req_wdata[7:0]}};
        end
        3'b001: begin
          be       = lane[1] ? 4'b1100 : 4'b0011;
          wd_lanes = {2{req_wdata[15:0]}};
        end
        3'b010:  be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  // Only one request is ever in flight, so a single holding register
  // carries the result until the counter reaches zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = RELOAD;
          data_d  = ld_val;
          err_d   = fault;
        end
      end
      BUSY: begin
        if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else if (accept) begin
          cnt_d  = RELOAD;
          data_d = ld_val;
          err_d  = fault;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    fire_d = (state_d == BUSY) && (cnt_d == 2'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      data_q       <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      err_q        <= err_d;
      resp_valid_q <= fire_d;
      resp_rdata_q <= fire_d ? data_d : 32'h0;
      resp_error_q <= fire_d & err_d;
    end
  end

  // Image is reloaded on every edge while reset stays high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= initial_values;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem_q[idx][8*k +: 8] <= wd_lanes[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_unit.sv
module tb_data_memory_unit;

  localparam int D = 16;
  localparam int LAT [3] = '{2, 1, 3};

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rv [3];
  logic              req_write = 1'b0;
  logic [2:0]        req_funct3 = 3'b010;
  logic [31:0]       req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic [D-1:0][31:0] init_vals;
  logic              rdy [3];
  logic              rsp_v [3];
  logic [31:0]       rsp_d [3];
  logic              rsp_e [3];
  logic [D-1:0][31:0] mc [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_memory_unit #(.DEPTH_WORDS(D), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rsp_v[0]), .resp_rdata(rsp_d[0]),
    .resp_error(rsp_e[0]), .initial_values(init_vals), .memory_check(mc[0]));

  data_memory_unit #(.DEPTH_WORDS(D), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rsp_v[1]), .resp_rdata(rsp_d[1]),
    .resp_error(rsp_e[1]), .initial_values(init_vals), .memory_check(mc[1]));

  data_memory_unit #(.DEPTH_WORDS(D), .LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(rv[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(rsp_v[2]), .resp_rdata(rsp_d[2]),
    .resp_error(rsp_e[2]), .initial_values(init_vals), .memory_check(mc[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One request on instance sel, then watch every cycle up to the response.
  task automatic do_req(input int sel, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    @(negedge clk);
    chk({tag, ".ready"}, 32'(rdy[sel]), 32'd1);
    chk({tag, ".idle_v"}, 32'(rsp_v[sel]), 32'd0);
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    rv[sel]    = 1'b1;
    @(posedge clk);
    #1 rv[sel] = 1'b0;
    for (int k = 0; k < LAT[sel]; k++) begin
      @(negedge clk);
      if (k == LAT[sel] - 1) begin
        chk({tag, ".v"}, 32'(rsp_v[sel]), 32'd1);
        chk({tag, ".rdata"}, rsp_d[sel], exp_d);
        chk({tag, ".err"}, 32'(rsp_e[sel]), 32'(exp_e));
      end else begin
        chk({tag, ".early_v"}, 32'(rsp_v[sel]), 32'd0);
        chk({tag, ".early_d"}, rsp_d[sel], 32'd0);
      end
    end
  endtask

  logic        bb_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] bb_wd [4] = '{32'd7, 32'd0, 32'd9, 32'd0};
  logic [31:0] bb_ex [4] = '{32'd0, 32'd7, 32'd0, 32'd9};

  initial begin
    for (int i = 0; i < 3; i++) rv[i] = 1'b0;
    init_vals    = '0;
    init_vals[3] = 32'h8000_00F1;
    init_vals[2] = 32'h1234_5678;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.v", 32'(rsp_v[0]), 32'd0);
    chk("rst.d", rsp_d[0], 32'd0);
    chk("rst.e", 32'(rsp_e[0]), 32'd0);
    chk("rst.mem3", mc[0][3], 32'h8000_00F1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(rdy[0]), 32'd1);

    // LATENCY = 2 instance
    do_req(0, 1'b0, 3'b010, 32'h0C, 32'h0, 32'h8000_00F1, 1'b0, "lw_init");

    do_req(0, 1'b1, 3'b010, 32'h0, 32'h1122_3344, 32'h0, 1'b0, "sw0");
    chk("sw0.mem", mc[0][0], 32'h1122_3344);
    do_req(0, 1'b1, 3'b000, 32'h1, 32'hFFFF_FFAA, 32'h0, 1'b0, "sb1");
    chk("sb1.mem", mc[0][0], 32'h1122_AA44);
    do_req(0, 1'b1, 3'b001, 32'h2, 32'h1234_BEEF, 32'h0, 1'b0, "sh2");
    chk("sh2.mem", mc[0][0], 32'hBEEF_AA44);

    do_req(0, 1'b0, 3'b000, 32'h1, 32'h0, 32'hFFFF_FFAA, 1'b0, "lb1");
    do_req(0, 1'b0, 3'b100, 32'h1, 32'h0, 32'h0000_00AA, 1'b0, "lbu1");
    do_req(0, 1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF_BEEF, 1'b0, "lh2");
    do_req(0, 1'b0, 3'b101, 32'h2, 32'h0, 32'h0000_BEEF, 1'b0, "lhu2");
    do_req(0, 1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFF_FFBE, 1'b0, "lb3");
    do_req(0, 1'b0, 3'b001, 32'h0, 32'h0, 32'hFFFF_AA44, 1'b0, "lh0");

    // Faults
    do_req(0, 1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, "lw_mis");
    do_req(0, 1'b1, 3'b001, 32'h5, 32'hFFFF_FFFF, 32'h0, 1'b1, "sh_mis");
    chk("sh_mis.mem", mc[0][1], 32'h0);
    do_req(0, 1'b0, 3'b010, 32'(4*D), 32'h0, 32'h0, 1'b1, "lw_range");
    do_req(0, 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, "f3_011");
    do_req(0, 1'b1, 3'b100, 32'h4, 32'hFFFF_FFFF, 32'h0, 1'b1, "sbu");
    chk("sbu.mem", mc[0][1], 32'h0);
    chk("faults.mem0", mc[0][0], 32'hBEEF_AA44);

    // LATENCY = 1 back-to-back
    @(negedge clk);
    req_write = bb_wr[0]; req_funct3 = 3'b010; req_addr = 32'h8; req_wdata = bb_wd[0];
    rv[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bb.ready", 32'(rdy[1]), 32'd1);
      chk("bb.v", 32'(rsp_v[1]), 32'd1);
      chk("bb.rdata", rsp_d[1], bb_ex[i]);
      chk("bb.err", 32'(rsp_e[1]), 32'd0);
      if (i < 3) begin
        req_write = bb_wr[i+1]; req_wdata = bb_wd[i+1];
      end else begin
        rv[1] = 1'b0;
      end
    end
    @(negedge clk);
    chk("bb.tail_v", 32'(rsp_v[1]), 32'd0);
    chk("bb.tail_d", rsp_d[1], 32'd0);
    chk("bb.mem", mc[1][2], 32'd9);

    // LATENCY = 3 with reset mid-flight
    do_req(2, 1'b1, 3'b010, 32'h8, 32'h0000_DEAD, 32'h0, 1'b0, "l3_sw");
    chk("l3_sw.mem", mc[2][2], 32'h0000_DEAD);
    @(negedge clk);
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8;
    rv[2] = 1'b1;
    @(posedge clk);
    #1 rv[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid.v", 32'(rsp_v[2]), 32'd0);
    chk("mid.d", rsp_d[2], 32'd0);
    chk("mid.e", 32'(rsp_e[2]), 32'd0);
    chk("mid.reload", mc[2][2], 32'h1234_5678);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid.ready", 32'(rdy[2]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid.no_v", 32'(rsp_v[2]), 32'd0);
      chk("mid.no_d", rsp_d[2], 32'd0);
    end
    chk("mid.mem3", mc[2][3], 32'h8000_00F1);
    chk("mid.l2mem0", mc[0][0], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory_unit.md
# data_memory_unit

Parametrised byte-addressable data memory for the RV32I core. It replaces the word-only, zero-latency store with a valid/ready request port and full LB/LH/LW/LBU/LHU/SB/SH support. It also adds alignment and range checking and a configurable read latency, so the core can later move to multi-cycle or pipelined execution. It sits between the ALU address path and the register write-back mux.

## Interface
- DEPTH_WORDS, 32: number of 32-bit words; power of two, 4..4096; AW = clog2(DEPTH_WORDS).
- LATENCY, 1: cycles from request handshake to response; legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, low-aligned (bits [7:0] for SB, [15:0] for SH).
- resp_valid  out  1  one-cycle response strobe; there is no response backpressure.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  request faulted; valid only with resp_valid.
- initial_values  in  32 x DEPTH_WORDS  memory image loaded during reset.
- memory_check  out  32 x DEPTH_WORDS  combinational view of every word, for benches.

## Operation
- Handshake: a request is accepted on a rising edge where req_valid && req_ready (edge E0). All request fields are sampled at E0 only.
- State machine:
  - IDLE: req_ready = 1.
  - BUSY: a counter runs from LATENCY-1 down to 0. resp_valid = 1 only in the BUSY cycle where the counter is 0.
  - req_ready = (state == IDLE) || resp_valid. A new request may therefore be accepted in the response cycle.
  - Transitions:
    - IDLE -> BUSY on accept.
    - BUSY (counter 0) -> BUSY with the counter reloaded on a new accept; otherwise -> IDLE.
- Address decode: word index = req_addr[AW+1:2]; lane = req_addr[1:0].
- Error conditions, checked at E0:
  - H/HU with addr[0] = 1.
  - W with addr[1:0] != 0.
  - funct3 in {011, 110, 111}.
  - req_write with funct3 in {100, 101}.
  - req_addr >= 4*DEPTH_WORDS.
- On an error: no memory write, resp_rdata = 0, resp_error = 1.
- Stores commit to the array at E0 with per-byte enables:
  - SB writes lane addr[1:0] from wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0].
  - SW writes all four lanes.
  - Unselected bytes are unchanged.
- Loads read the addressed word at E0, before any same-edge write; none is possible, since only one request is accepted per edge. The extracted, extended value is held in the pipeline.
  - B: sign-extend the selected byte. BU: zero-extend it.
  - H: sign-extend the selected half. HU: zero-extend it.
  - W: the whole word.
- Ordering: a load accepted after a store always sees the store's data.
- Reset, asserted at any time:
  - state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_error = 0.
  - mem[i] = initial_values[i], held continuously while reset is high.
  - Any in-flight response is discarded and never emitted.
  - req_ready = 1 on the first cycle after reset deasserts.

## Timing
- Response appears exactly LATENCY cycles after the handshake cycle. resp_valid is high for exactly one cycle per accepted request.
- resp_rdata and resp_error are registered. They return to 0 in every cycle where resp_valid = 0.
- Throughput:
  - LATENCY = 1: one request per cycle.
  - LATENCY = L: one request per L cycles.
- memory_check reflects a store from the cycle after E0.
- No combinational path from req_* to resp_*. req_ready depends only on registered state.

## Test plan
- Reset load: initial_values[3] = 0x8000_00F1, reset pulse, then LW addr 0x0C with LATENCY = 2 -> resp_valid exactly 2 cycles after the handshake, rdata 0x8000_00F1, error 0.
- Sub-word stores: SW 0x0 <- 0x1122_3344; SB 0x1 <- 0xAA; SH 0x2 <- 0xBEEF -> memory_check[0] = 0xBEEF_AA44.
- Load extension on word 0xBEEF_AA44:
  - LB 0x1 -> 0xFFFF_FFAA; LBU 0x1 -> 0x0000_00AA.
  - LH 0x2 -> 0xFFFF_BEEF; LHU 0x2 -> 0x0000_BEEF.
- Errors:
  - LW 0x2 -> error 1, rdata 0.
  - SH 0x5 -> error 1, memory unchanged.
  - LW 4*DEPTH_WORDS -> error 1.
  - funct3 011 -> error 1.
- Back-to-back with LATENCY = 1: req_valid held for 4 consecutive requests (SW 0x8 <- 7, LW 0x8, SW 0x8 <- 9, LW 0x8) -> req_ready constantly 1, responses on 4 consecutive cycles with load data 7 then 9.
- Reset mid-operation: LATENCY = 3, accept LW, assert reset one cycle later -> no resp_valid ever appears for that request, all outputs 0, memory reloaded from initial_values.
